// File: rtl/inst_fifo_packer.sv
// Pairs 32-bit bus writes into 64-bit instructions for the timing controller FIFO; write strobe one cycle after the second word.
// Optional stall statistics (dbg_stall_cycles, dbg_max_stall) are enabled by defining INST_PACKER_STALL_STATS_EN.
module inst_fifo_packer #(
   parameter int BUS_DATA_WIDTH = 32,
   parameter int COUNT_WIDTH    = 32
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        init,
   input  logic                        bus_wr_valid,
   input  logic [BUS_DATA_WIDTH-1:0]   bus_wr_data,
   output logic                        bus_wr_ready,
   input  logic                        inst_fifo_full,
   input  logic                        inst_fifo_almost_full,
   output logic [2*BUS_DATA_WIDTH-1:0] inst_fifo_wr_data,
   output logic                        inst_fifo_wr_en,
   output logic                        pulse_controller_release,
   output logic                        half_word_pending,
   output logic [COUNT_WIDTH-1:0]      dbg_inst_written
`ifdef INST_PACKER_STALL_STATS_EN
   ,
   output logic [COUNT_WIDTH-1:0]      dbg_stall_cycles,
   output logic [COUNT_WIDTH-1:0]      dbg_max_stall
`endif
);

   typedef enum logic [1:0] {
      LO   = 2'd0,
      HI   = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t                      state;
   state_t                      state_nxt;
   logic                        rst_done;
   logic                        xfer;
   logic [BUS_DATA_WIDTH-1:0]   lo_word;
   logic                        af_hist;

   // rst_done keeps ready low while reset is asserted and until the first edge after it
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= LO;
         rst_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         rst_done <= 1'b1;
      end
   end

   always_comb begin
      state_nxt         = state;
      bus_wr_ready      = 1'b0;
      inst_fifo_wr_en   = 1'b0;
      half_word_pending = 1'b0;
      case (state)
         LO: begin
            bus_wr_ready = rst_done;
            if (bus_wr_valid && rst_done) state_nxt = HI;
         end
         HI: begin
            bus_wr_ready      = 1'b1;
            half_word_pending = 1'b1;
            if (bus_wr_valid) state_nxt = PEND;
         end
         PEND: begin
            bus_wr_ready    = ~inst_fifo_full;
            inst_fifo_wr_en = ~inst_fifo_full;
            if (!inst_fifo_full) state_nxt = bus_wr_valid ? HI : LO;
         end
         default: state_nxt = LO;
      endcase
      if (init) begin
         state_nxt       = LO;
         bus_wr_ready    = 1'b0;
         inst_fifo_wr_en = 1'b0;
      end
   end

   assign xfer = bus_wr_valid & bus_wr_ready;

   // First word lands in the upper half: the FIFO fills MSB first and the consumer swaps halves
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lo_word           <= '0;
         inst_fifo_wr_data <= '0;
      end else if (init) begin
         lo_word           <= '0;
      end else if (xfer) begin
         if (state == HI) inst_fifo_wr_data <= {lo_word, bus_wr_data};
         else             lo_word           <= bus_wr_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)              dbg_inst_written <= '0;
      else if (init)            dbg_inst_written <= '0;
      else if (inst_fifo_wr_en) dbg_inst_written <= dbg_inst_written + COUNT_WIDTH'(1);
   end

   // History follows the input during init so leaving init cannot fake a rising edge
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         af_hist                  <= 1'b0;
         pulse_controller_release <= 1'b0;
      end else begin
         af_hist                  <= inst_fifo_almost_full;
         pulse_controller_release <= ~init & inst_fifo_almost_full & ~af_hist;
      end
   end

`ifdef INST_PACKER_STALL_STATS_EN
   logic                   stall;
   logic [COUNT_WIDTH-1:0] cur_run;

   assign stall = (state == PEND) && inst_fifo_full;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dbg_stall_cycles <= '0;
         dbg_max_stall    <= '0;
         cur_run          <= '0;
      end else if (init) begin
         dbg_stall_cycles <= '0;
         dbg_max_stall    <= '0;
         cur_run          <= '0;
      end else if (stall) begin
         if (!(&dbg_stall_cycles)) dbg_stall_cycles <= dbg_stall_cycles + COUNT_WIDTH'(1);
         if (!(&cur_run))          cur_run          <= cur_run + COUNT_WIDTH'(1);
      end else if (cur_run != '0) begin
         if (cur_run > dbg_max_stall) dbg_max_stall <= cur_run;
         cur_run <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fifo_packer.sv
// Directed bench for inst_fifo_packer: packing, streaming, full stall, init flush, release pulses, async reset.
module tb_inst_fifo_packer;

   logic        clock = 1'b0;
   logic        resetn;
   logic        init;
   logic        bus_wr_valid;
   logic [31:0] bus_wr_data;
   logic        bus_wr_ready;
   logic        inst_fifo_full;
   logic        inst_fifo_almost_full;
   logic [63:0] inst_fifo_wr_data;
   logic        inst_fifo_wr_en;
   logic        pulse_controller_release;
   logic        half_word_pending;
   logic [31:0] dbg_inst_written;
`ifdef INST_PACKER_STALL_STATS_EN
   logic [31:0] dbg_stall_cycles;
   logic [31:0] dbg_max_stall;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int writes;
   int pulses;

   always #5 clock = ~clock;

   inst_fifo_packer #(.BUS_DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
      .clock                    (clock),
      .resetn                   (resetn),
      .init                     (init),
      .bus_wr_valid             (bus_wr_valid),
      .bus_wr_data              (bus_wr_data),
      .bus_wr_ready             (bus_wr_ready),
      .inst_fifo_full           (inst_fifo_full),
      .inst_fifo_almost_full    (inst_fifo_almost_full),
      .inst_fifo_wr_data        (inst_fifo_wr_data),
      .inst_fifo_wr_en          (inst_fifo_wr_en),
      .pulse_controller_release (pulse_controller_release),
      .half_word_pending        (half_word_pending),
      .dbg_inst_written         (dbg_inst_written)
`ifdef INST_PACKER_STALL_STATS_EN
      ,
      .dbg_stall_cycles         (dbg_stall_cycles),
      .dbg_max_stall            (dbg_max_stall)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetn = 1'b0; init = 1'b0; bus_wr_valid = 1'b0; bus_wr_data = '0;
      inst_fifo_full = 1'b0; inst_fifo_almost_full = 1'b0;
      #2;
      chk("rst_ready",   64'(bus_wr_ready), 64'd0);
      chk("rst_wr_en",   64'(inst_fifo_wr_en), 64'd0);
      chk("rst_wr_data", inst_fifo_wr_data, 64'd0);
      chk("rst_release", 64'(pulse_controller_release), 64'd0);
      chk("rst_hwp",     64'(half_word_pending), 64'd0);
      chk("rst_dbg",     64'(dbg_inst_written), 64'd0);
      cyc();
      chk("rst_ready_edge", 64'(bus_wr_ready), 64'd0);
      resetn = 1'b1;
      cyc();
      #1 chk("post_rst_ready", 64'(bus_wr_ready), 64'd1);

      // single pair
      bus_wr_valid = 1'b1; bus_wr_data = 32'h1111_1111;
      #1 chk("t1_ready_lo", 64'(bus_wr_ready), 64'd1);
      cyc();
      bus_wr_data = 32'h2222_2222;
      #1 chk("t1_hwp", 64'(half_word_pending), 64'd1);
      chk("t1_wr_en_hi", 64'(inst_fifo_wr_en), 64'd0);
      cyc();
      bus_wr_valid = 1'b0;
      #1 chk("t1_wr_en", 64'(inst_fifo_wr_en), 64'd1);
      chk("t1_wr_data", inst_fifo_wr_data, 64'h1111_1111_2222_2222);
      chk("t1_hwp_pend", 64'(half_word_pending), 64'd0);
      cyc();
      #1 chk("t1_wr_en_off", 64'(inst_fifo_wr_en), 64'd0);
      chk("t1_dbg", 64'(dbg_inst_written), 64'd1);
      chk("t1_lo_state", 64'(half_word_pending), 64'd0);

      // init clears counter
      init = 1'b1;
      #1 chk("init_ready", 64'(bus_wr_ready), 64'd0);
      cyc();
      init = 1'b0;
      #1 chk("init_dbg", 64'(dbg_inst_written), 64'd0);
      chk("init_ready_after", 64'(bus_wr_ready), 64'd1);

      // stream of 8 words
      writes = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < 8) begin
            bus_wr_valid = 1'b1; bus_wr_data = 32'h100 + 32'(c);
         end else begin
            bus_wr_valid = 1'b0;
         end
         #1;
         if (c < 8) chk("t2_ready", 64'(bus_wr_ready), 64'd1);
         chk("t2_wr_en", 64'(inst_fifo_wr_en), 64'(c >= 2 && c % 2 == 0));
         if (inst_fifo_wr_en) begin
            chk("t2_wr_data", inst_fifo_wr_data,
                {32'h100 + 32'(c - 2), 32'h101 + 32'(c - 2)});
            writes++;
         end
         cyc();
      end
      #1 chk("t2_writes", 64'(writes), 64'd4);
      chk("t2_dbg", 64'(dbg_inst_written), 64'd4);

      // full stall of 10 cycles
      bus_wr_valid = 1'b1; bus_wr_data = 32'h3333_3333;
      #1;
      cyc();
      bus_wr_data = 32'h4444_4444; inst_fifo_full = 1'b1;
      #1 chk("t3_hwp", 64'(half_word_pending), 64'd1);
      chk("t3_ready_hi", 64'(bus_wr_ready), 64'd1);
      cyc();
      bus_wr_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("t3_ready_full", 64'(bus_wr_ready), 64'd0);
         chk("t3_wr_en_full", 64'(inst_fifo_wr_en), 64'd0);
         if (c == 9) chk("t3_hold", inst_fifo_wr_data, 64'h3333_3333_4444_4444);
         cyc();
      end
      inst_fifo_full = 1'b0;
      #1 chk("t3_wr_en", 64'(inst_fifo_wr_en), 64'd1);
      chk("t3_ready", 64'(bus_wr_ready), 64'd1);
      chk("t3_wr_data", inst_fifo_wr_data, 64'h3333_3333_4444_4444);
      cyc();
      #1 chk("t3_wr_en_off", 64'(inst_fifo_wr_en), 64'd0);
      chk("t3_dbg", 64'(dbg_inst_written), 64'd5);
`ifdef INST_PACKER_STALL_STATS_EN
      chk("t3_stall", 64'(dbg_stall_cycles), 64'd10);
      chk("t3_max", 64'(dbg_max_stall), 64'd10);
`endif

      // init discards half word
      bus_wr_valid = 1'b1; bus_wr_data = 32'hAAAA_0000;
      #1;
      cyc();
      bus_wr_valid = 1'b0; init = 1'b1;
      #1 chk("t4_hwp_before", 64'(half_word_pending), 64'd1);
      chk("t4_ready_init", 64'(bus_wr_ready), 64'd0);
      chk("t4_wr_en_init", 64'(inst_fifo_wr_en), 64'd0);
      cyc();
      init = 1'b0;
      #1 chk("t4_hwp_after", 64'(half_word_pending), 64'd0);
      chk("t4_dbg_clr", 64'(dbg_inst_written), 64'd0);
`ifdef INST_PACKER_STALL_STATS_EN
      chk("t4_stall_clr", 64'(dbg_stall_cycles), 64'd0);
      chk("t4_max_clr", 64'(dbg_max_stall), 64'd0);
`endif
      bus_wr_valid = 1'b1; bus_wr_data = 32'h1;
      cyc();
      bus_wr_data = 32'h2;
      cyc();
      bus_wr_valid = 1'b0;
      #1 chk("t4_wr_en", 64'(inst_fifo_wr_en), 64'd1);
      chk("t4_wr_data", inst_fifo_wr_data, 64'h0000_0001_0000_0002);
      cyc();
      #1 chk("t4_dbg", 64'(dbg_inst_written), 64'd1);

      // almost_full release pulses
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         inst_fifo_almost_full = (c < 20) || (c >= 25);
         #1;
         chk("t5_release", 64'(pulse_controller_release), 64'(c == 1 || c == 26));
         if (pulse_controller_release) pulses++;
         cyc();
      end
      inst_fifo_almost_full = 1'b0;
      #1 chk("t5_pulses", 64'(pulses), 64'd2);
      cyc();

      // async reset while stalled in PEND
      bus_wr_valid = 1'b1; bus_wr_data = 32'h5555_5555;
      #1;
      cyc();
      bus_wr_data = 32'h6666_6666; inst_fifo_full = 1'b1; inst_fifo_almost_full = 1'b1;
      #1;
      cyc();
      bus_wr_valid = 1'b0;
      #1 chk("t6_ready_full", 64'(bus_wr_ready), 64'd0);
      chk("t6_wr_en_full", 64'(inst_fifo_wr_en), 64'd0);
      chk("t6_release_hi", 64'(pulse_controller_release), 64'd1);
      inst_fifo_full = 1'b0;
      #1 chk("t6_wr_en_comb", 64'(inst_fifo_wr_en), 64'd1);
      resetn = 1'b0;
      #1 chk("t6_wr_en_async", 64'(inst_fifo_wr_en), 64'd0);
      chk("t6_ready_async", 64'(bus_wr_ready), 64'd0);
      chk("t6_release_async", 64'(pulse_controller_release), 64'd0);
      chk("t6_dbg_async", 64'(dbg_inst_written), 64'd0);
      chk("t6_wr_data_async", inst_fifo_wr_data, 64'd0);
      inst_fifo_almost_full = 1'b0;
      cyc();
      resetn = 1'b1;
      cyc();
      #1 chk("t6_ready_after", 64'(bus_wr_ready), 64'd1);
      bus_wr_valid = 1'b1; bus_wr_data = 32'h7777_7777;
      cyc();
      bus_wr_data = 32'h8888_8888;
      cyc();
      bus_wr_valid = 1'b0;
      #1 chk("t6_wr_en", 64'(inst_fifo_wr_en), 64'd1);
      chk("t6_wr_data", inst_fifo_wr_data, 64'h7777_7777_8888_8888);
      cyc();
      #1 chk("t6_dbg", 64'(dbg_inst_written), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
